// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions: register-address width and the EX operand-mux
// select encoding used by the forwarding logic and the datapath mux.
package hazard_forward_unit_pkg;

  localparam int PIPE_AW = 5;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight writer of src,
// never forwarding register 0.
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW = PIPE_AW
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] exmem_dst,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] memwb_dst,
  input  logic          memwb_regwrite,
  output logic [1:0]    sel
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_regwrite && (exmem_dst != '0) && (exmem_dst == src);
  assign memwb_hit = memwb_regwrite && (memwb_dst != '0) && (memwb_dst == src);

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    sel = FWD_IDEX;
    if (exmem_hit)
      sel = FWD_EXMEM;
    else if (memwb_hit)
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX-stage operand forwarding for a 5-stage
// pipeline, with a saturating count of stall cycles.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW = PIPE_AW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [AW-1:0] id_dst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  logic [AW-1:0] idex_rs_p0;
  logic [AW-1:0] idex_rt_p0;
  logic [AW-1:0] idex_dst_p0;
  logic          idex_regwrite_p0;
  logic          idex_memread_p0;
  logic [AW-1:0] exmem_dst_p1;
  logic          exmem_regwrite_p1;
  logic [AW-1:0] memwb_dst_p2;
  logic          memwb_regwrite_p2;
  logic          bubble;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign stall = idex_memread_p0 && (idex_dst_p0 != '0) &&
                 ((idex_dst_p0 == id_rs) || (id_uses_rt && (idex_dst_p0 == id_rt)));
  assign bubble = stall || flush;

  // ID -> ID/EX; sources still load on a bubble so forwarding stays harmless
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_rs_p0       <= '0;
      idex_rt_p0       <= '0;
      idex_dst_p0      <= '0;
      idex_regwrite_p0 <= 1'b0;
      idex_memread_p0  <= 1'b0;
    end else begin
      idex_rs_p0       <= id_rs;
      idex_rt_p0       <= id_rt;
      idex_dst_p0      <= bubble ? '0 : id_dst;
      idex_regwrite_p0 <= bubble ? 1'b0 : id_regwrite;
      idex_memread_p0  <= bubble ? 1'b0 : id_memread;
    end
  end

  // ID/EX -> EX/MEM -> MEM/WB
  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_dst_p1      <= '0;
      exmem_regwrite_p1 <= 1'b0;
      memwb_dst_p2      <= '0;
      memwb_regwrite_p2 <= 1'b0;
    end else begin
      exmem_dst_p1      <= idex_dst_p0;
      exmem_regwrite_p1 <= idex_regwrite_p0;
      memwb_dst_p2      <= exmem_dst_p1;
      memwb_regwrite_p2 <= exmem_regwrite_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= sat_inc(stall_cnt);
  end

  fwd_select #(.AW(AW)) u_fwd_a (
    .src            (idex_rs_p0),
    .exmem_dst      (exmem_dst_p1),
    .exmem_regwrite (exmem_regwrite_p1),
    .memwb_dst      (memwb_dst_p2),
    .memwb_regwrite (memwb_regwrite_p2),
    .sel            (fwd_a)
  );

  fwd_select #(.AW(AW)) u_fwd_b (
    .src            (idex_rt_p0),
    .exmem_dst      (exmem_dst_p1),
    .exmem_regwrite (exmem_regwrite_p1),
    .memwb_dst      (memwb_dst_p2),
    .memwb_regwrite (memwb_regwrite_p2),
    .sel            (fwd_b)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed pipeline scenarios plus random
// instruction streams checked against an instruction-slot reference model.
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rt;
  logic [AW-1:0] id_dst;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  hazard_forward_unit #(.AW(AW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_dst      (id_dst),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one record per instruction in flight.
  // Slot 0 = in EX, slot 1 = in MEM, slot 2 = in WB.
  typedef struct {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    bit            writes;
    bit            loads;
  } instr_t;

  instr_t pipe [3];
  int     cnt;

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    for (int k = 1; k <= 2; k++)
      if (pipe[k].writes && pipe[k].dst != 0 && pipe[k].dst == src)
        return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_stall();
    if (!pipe[0].loads || pipe[0].dst == 0) return 1'b0;
    return (pipe[0].dst == id_rs) || (id_uses_rt && pipe[0].dst == id_rt);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      pipe[k].rs = '0; pipe[k].rt = '0; pipe[k].dst = '0;
      pipe[k].writes = 1'b0; pipe[k].loads = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit urt, input int dst,
                       input bit wr, input bit ld, input bit fl);
    id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rt = urt; id_dst = AW'(dst);
    id_regwrite = wr; id_memread = ld; flush = fl;
  endtask

  // Compare the current cycle against the model, then advance one clock.
  task automatic tick();
    bit s;
    #1;
    s = model_stall();
    chk("stall", 32'(stall), 32'(s));
    chk("fwd_a", 32'(fwd_a), 32'(model_fwd(pipe[0].rs)));
    chk("fwd_b", 32'(fwd_b), 32'(model_fwd(pipe[0].rt)));
    chk("stall_cnt", 32'(stall_cnt), 32'(cnt));
    @(posedge clk);
    if (rst) begin
      model_clear();
      cnt = 0;
    end else begin
      if (s && cnt < CNT_MAX) cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0].rs = id_rs;
      pipe[0].rt = id_rt;
      pipe[0].dst    = (s || flush) ? '0 : id_dst;
      pipe[0].writes = (s || flush) ? 1'b0 : id_regwrite;
      pipe[0].loads  = (s || flush) ? 1'b0 : id_memread;
    end
    @(negedge clk);
  endtask

  task automatic step(input int rs, input int rt, input bit urt, input int dst,
                      input bit wr, input bit ld, input bit fl);
    drive(rs, rt, urt, dst, wr, ld, fl);
    tick();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    model_clear();
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;

    // First cycle after reset: arbitrary decode inputs must not stall or forward.
    drive(4, 4, 1, 4, 1, 1, 0);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fwd_a", 32'(fwd_a), 32'd0);
    chk("reset_fwd_b", 32'(fwd_b), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);
    tick();
    repeat (3) nop();

    // EX/MEM forward: add r3,r1,r2 ; sub r5,r3,r4
    step(1, 2, 1, 3, 1, 0, 0);
    step(3, 4, 1, 5, 1, 0, 0);
    chk("exmem_fwd_a", 32'(fwd_a), 32'd2);
    chk("exmem_fwd_b", 32'(fwd_b), 32'd0);
    nop(); nop(); nop();

    // MEM/WB forward: add r3 ; unrelated ; or r6,r7,r3
    step(1, 2, 1, 3, 1, 0, 0);
    step(9, 10, 1, 11, 1, 0, 0);
    step(7, 3, 1, 6, 1, 0, 0);
    chk("memwb_fwd_b", 32'(fwd_b), 32'd1);
    chk("memwb_fwd_a", 32'(fwd_a), 32'd0);
    nop(); nop(); nop();

    // Double hazard: add r2 ; add r2 ; and r8,r2,r2
    step(1, 1, 1, 2, 1, 0, 0);
    step(3, 4, 1, 2, 1, 0, 0);
    step(2, 2, 1, 8, 1, 0, 0);
    chk("double_fwd_a", 32'(fwd_a), 32'd2);
    chk("double_fwd_b", 32'(fwd_b), 32'd2);
    nop(); nop(); nop();

    // Load-use: lw r4 ; add r5,r4,r1
    base = cnt;
    step(1, 0, 0, 4, 1, 1, 0);
    drive(4, 1, 1, 5, 1, 0, 0);
    #1 chk("lu_stall_on", 32'(stall), 32'd1);
    tick();
    #1 chk("lu_stall_off", 32'(stall), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'(base + 1));
    tick();
    chk("lu_fwd_a", 32'(fwd_a), 32'd1);
    nop(); nop(); nop();

    // Register 0 never stalls or forwards.
    step(1, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 6, 1, 0, 0);
    #1 chk("r0_load_stall", 32'(stall), 32'd0);
    tick();
    step(1, 2, 1, 0, 1, 0, 0);
    step(0, 0, 1, 7, 1, 0, 0);
    chk("r0_fwd_a", 32'(fwd_a), 32'd0);
    chk("r0_fwd_b", 32'(fwd_b), 32'd0);
    nop(); nop(); nop();

    // Back-to-back loads each produce their own stall.
    step(1, 0, 0, 4, 1, 1, 0);
    drive(4, 0, 0, 6, 1, 1, 0);
    #1 chk("b2b_stall1", 32'(stall), 32'd1);
    tick();
    tick();
    drive(6, 2, 1, 9, 1, 0, 0);
    #1 chk("b2b_stall2", 32'(stall), 32'd1);
    tick();
    nop(); nop(); nop();

    // Flush together with stall: stall still shown, exactly one bubble.
    step(1, 0, 0, 4, 1, 1, 0);
    drive(4, 1, 1, 5, 1, 0, 1);
    #1 chk("flush_stall", 32'(stall), 32'd1);
    tick();
    step(4, 1, 1, 5, 1, 0, 0);
    nop(); nop(); nop();

    // Reset during a stall discards the hazard.
    step(1, 0, 0, 4, 1, 1, 0);
    drive(4, 1, 1, 5, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_mid_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_mid_fwd_b", 32'(fwd_b), 32'd0);
    tick();
    nop(); nop();

    // Saturation of the stall counter.
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      step(1, 0, 0, 4, 1, 1, 0);
      step(4, 1, 1, 5, 1, 0, 0);
    end
    chk("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    step(1, 0, 0, 4, 1, 1, 0);
    step(4, 1, 1, 5, 1, 0, 0);
    chk("sat_hold", 32'(stall_cnt), 32'(CNT_MAX));

    // Random instruction streams with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));
    end
    rst = 1'b0;
    nop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
